// File: rtl/maze_wall_server.sv
// maze_wall_server
// Sweeps four ghost clients. For each one it latches the tile position, reads
// the four neighbouring maze tiles from a 1-bit maze ROM and writes that
// client's four wall flags in a single cycle. The maze is 28 x 36 tiles, and
// the tile address is y*28+x.
//
// Row 19 is the tunnel row. On it, the left neighbour of x=0 is x=27 and the
// right neighbour of x=27 is x=0. A neighbour that falls off the maze is a
// forced wall: no ROM read is issued for it and its flag is 1. A client
// position outside the maze gets all four flags forced to 1.
//
// Optional feature, WALL_GHOST_DOOR_EN: adds the doorOpen[3:0] input. When a
// client's doorOpen bit is latched as 1, the door tiles (13,15) and (14,15)
// read as open (0) for that client. The ROM read is still issued.
//
// Ports:
//   clk, reset (async, active-high)
//   scan                    pulse that starts a sweep; ignored while busy
//   posX, posY [23:0]       packed tile coordinates, client n at [6n+5:6n]
//   doorOpen [3:0]          per-client door override (WALL_GHOST_DOOR_EN only)
//   romEn, romAddr[9:0]     ROM read strobe and address; address holds while idle
//   romData                 wall bit, valid the cycle after romEn
//   wallUp/Down/Left/Right  registered per-client wall flags
//   wallValid [3:0]         one-cycle pulse when client n's flags are written
//   busy                    high while a sweep is in progress
//   sweepDone               one-cycle pulse after client 3 is written
module maze_wall_server (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan,
  input  logic [23:0] posX,
  input  logic [23:0] posY,
`ifdef WALL_GHOST_DOOR_EN
  input  logic [3:0]  doorOpen,
`endif
  output logic        romEn,
  output logic [9:0]  romAddr,
  input  logic        romData,
  output logic [3:0]  wallUp,
  output logic [3:0]  wallDown,
  output logic [3:0]  wallLeft,
  output logic [3:0]  wallRight,
  output logic [3:0]  wallValid,
  output logic        busy,
  output logic        sweepDone
);

  typedef enum logic [2:0] {IDLE, LATCH, RD_U, RD_D, RD_L, RD_R, WB} state_t;

  state_t      state, stateNext;
  logic [1:0]  client;
  logic [5:0]  curX, curY;
  logic        upT, downT, leftT;
  logic        pendForced, pendDoor;
  logic [9:0]  romAddrHold;
  logic        doorLat;

  // Neighbour of the tile for the current read slot
  logic [5:0]  nbX, nbY;
  logic        forced, isRead, isDoor, oob, capVal;
  logic [9:0]  addrComb, yW;
  logic [4:0]  base;

  assign busy = (state != IDLE);
  assign oob  = (curX > 6'd27) || (curY > 6'd35);
  // The packed field for client n starts at bit 6n (n*4 + n*2).
  assign base = {1'b0, client, 2'b00} + {2'b00, client, 1'b0};

  always_comb begin
    nbX    = curX;
    nbY    = curY;
    forced = 1'b1;
    isRead = 1'b0;
    case (state)
      RD_U: begin
        isRead = 1'b1;
        nbY    = curY - 6'd1;
        forced = oob || (curY == 6'd0);
      end
      RD_D: begin
        isRead = 1'b1;
        nbY    = curY + 6'd1;
        forced = oob || (curY == 6'd35);
      end
      RD_L: begin
        isRead = 1'b1;
        if (curX == 6'd0) begin
          nbX    = 6'd27;                  // wraps only on the tunnel row
          forced = oob || (curY != 6'd19);
        end else begin
          nbX    = curX - 6'd1;
          forced = oob;
        end
      end
      RD_R: begin
        isRead = 1'b1;
        if (curX == 6'd27) begin
          nbX    = 6'd0;
          forced = oob || (curY != 6'd19);
        end else begin
          nbX    = curX + 6'd1;
          forced = oob;
        end
      end
      default: ;
    endcase
  end

  // y*28 + x, computed as y*16 + y*8 + y*4 + x
  assign yW       = {4'd0, nbY};
  assign addrComb = (yW << 4) + (yW << 3) + (yW << 2) + {4'd0, nbX};

`ifdef WALL_GHOST_DOOR_EN
  assign isDoor = doorLat && (nbY == 6'd15) && ((nbX == 6'd13) || (nbX == 6'd14));
`else
  assign isDoor  = 1'b0;
  assign doorLat = 1'b0;
`endif

  assign romEn   = isRead && !forced;
  assign romAddr = romEn ? addrComb : romAddrHold;

  // The read issued in the previous slot lands in this cycle.
  assign capVal = pendForced ? 1'b1 : (pendDoor ? 1'b0 : romData);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (scan) stateNext = LATCH;
      LATCH:   stateNext = RD_U;
      RD_U:    stateNext = RD_D;
      RD_D:    stateNext = RD_L;
      RD_L:    stateNext = RD_R;
      RD_R:    stateNext = WB;
      WB:      stateNext = (client == 2'd3) ? IDLE : LATCH;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      client      <= 2'd0;
      curX        <= 6'd0;
      curY        <= 6'd0;
      upT         <= 1'b1;
      downT       <= 1'b1;
      leftT       <= 1'b1;
      pendForced  <= 1'b1;
      pendDoor    <= 1'b0;
      romAddrHold <= 10'd0;
      wallUp      <= 4'hF;
      wallDown    <= 4'hF;
      wallLeft    <= 4'hF;
      wallRight   <= 4'hF;
      wallValid   <= 4'h0;
      sweepDone   <= 1'b0;
    end else begin
      state     <= stateNext;
      wallValid <= 4'h0;
      sweepDone <= 1'b0;
      if (romEn) romAddrHold <= addrComb;
      if (isRead) begin
        pendForced <= forced;
        pendDoor   <= isDoor;
      end
      case (state)
        LATCH: begin
          curX <= posX[base +: 6];
          curY <= posY[base +: 6];
        end
        RD_D: upT   <= capVal;
        RD_L: downT <= capVal;
        RD_R: leftT <= capVal;
        WB: begin
          wallUp[client]    <= upT;
          wallDown[client]  <= downT;
          wallLeft[client]  <= leftT;
          wallRight[client] <= capVal;
          wallValid[client] <= 1'b1;
          if (client == 2'd3) sweepDone <= 1'b1;
          client <= client + 2'd1;         // wraps to 0 for the next sweep
        end
        default: ;
      endcase
    end
  end

`ifdef WALL_GHOST_DOOR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              doorLat <= 1'b0;
    else if (state == LATCH) doorLat <= doorOpen[client];
  end
`endif

endmodule

// File: tb/tb_maze_wall_server.sv
module tb_maze_wall_server;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan;
  logic [23:0] posX, posY;
  logic        romEn;
  logic [9:0]  romAddr;
  logic        romData;
  logic [3:0]  wallUp, wallDown, wallLeft, wallRight, wallValid;
  logic        busy, sweepDone;
`ifdef WALL_GHOST_DOOR_EN
  logic [3:0]  doorOpen;
`endif

  maze_wall_server dut (
    .clk(clk), .reset(reset), .scan(scan), .posX(posX), .posY(posY),
`ifdef WALL_GHOST_DOOR_EN
    .doorOpen(doorOpen),
`endif
    .romEn(romEn), .romAddr(romAddr), .romData(romData),
    .wallUp(wallUp), .wallDown(wallDown), .wallLeft(wallLeft), .wallRight(wallRight),
    .wallValid(wallValid), .busy(busy), .sweepDone(sweepDone)
  );

  always #5 clk = ~clk;

  // Maze ROM model: one-cycle read latency.
  logic mem [0:1023];
  always @(posedge clk) if (romEn) romData <= mem[romAddr];

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Per-cycle logs for one sweep; k=1 is the cycle the DUT sits in LATCH of client 0.
  logic       enL [0:40];
  logic [9:0] adL [0:40];
  logic [3:0] vL  [0:40];
  logic       dnL [0:40];
  logic       bzL [0:40];

  task automatic setPos(input int n, input int x, input int y);
    posX[n*6 +: 6] = x[5:0];
    posY[n*6 +: 6] = y[5:0];
  endtask

  // rescanK: cycle at which a second scan is raised; rstK: cycle at which
  // reset is asserted (sweep stops there); chgK: cycle at which client 0 x moves.
  task automatic runSweep(input int rescanK, input int rstK, input int chgK);
    for (int k = 0; k <= 40; k++) begin
      enL[k] = 0; adL[k] = 0; vL[k] = 0; dnL[k] = 0; bzL[k] = 0;
    end
    @(negedge clk);
    scan = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      scan = (k == rescanK);
      if (k == chgK) setPos(0, 10, 5);
      if (k == rstK) begin
        reset = 1'b1;
        #1;
        return;
      end
      enL[k] = romEn; adL[k] = romAddr; vL[k] = wallValid;
      dnL[k] = sweepDone; bzL[k] = busy;
    end
  endtask

  int doneCnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
    scan = 0; posX = '0; posY = '0;
`ifdef WALL_GHOST_DOOR_EN
    doorOpen = 4'b0000;
`endif
    reset = 1'b1;
    #1;
    chk("rst_wallUp", wallUp, 4'hF);
    chk("rst_wallDown", wallDown, 4'hF);
    chk("rst_wallLeft", wallLeft, 4'hF);
    chk("rst_wallRight", wallRight, 4'hF);
    chk("rst_valid", wallValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_romEn", romEn, 0);
    chk("rst_romAddr", romAddr, 0);
    chk("rst_done", sweepDone, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Walls at (6,4)=118 and (7,5)=147 only.
    mem[118] = 1'b1;
    mem[147] = 1'b1;
    setPos(0, 6, 5);
    setPos(1, 0, 19);
    setPos(2, 0, 0);
    setPos(3, 40, 10);

    // Sweep 1, with a second scan raised while busy.
    runSweep(4, 0, 0);
    chk("c0_en_up", enL[2], 1);
    chk("c0_addr_up", adL[2], 118);
    chk("c0_addr_down", adL[3], 174);
    chk("c0_addr_left", adL[4], 145);
    chk("c0_addr_right", adL[5], 147);
    chk("addr_hold_wb", adL[6], 147);
    chk("c0_valid_at6", vL[7], 4'b0001);
    chk("c0_valid_not5", vL[6], 0);
    chk("c1_addr_left_wrap", adL[10], 559);
    chk("c1_valid", vL[13], 4'b0010);
    chk("c2_no_rd_up", enL[14], 0);
    chk("c2_rd_down", enL[15], 1);
    chk("c2_no_rd_left", enL[16], 0);
    chk("c2_valid", vL[19], 4'b0100);
    chk("c3_no_rd", {28'd0, enL[20], enL[21], enL[22], enL[23]}, 0);
    chk("c3_valid", vL[25], 4'b1000);
    chk("busy_latch", bzL[1], 1);
    chk("busy_last", bzL[24], 1);
    chk("busy_end", bzL[25], 0);
    chk("done_at24", dnL[25], 1);
    doneCnt = 0;
    for (int k = 1; k <= 40; k++) doneCnt += dnL[k];
    chk("done_once", doneCnt, 1);
    chk("no_rescan", bzL[30], 0);
    chk("wallUp", wallUp, 4'b1101);
    chk("wallDown", wallDown, 4'b1000);
    chk("wallLeft", wallLeft, 4'b1100);
    chk("wallRight", wallRight, 4'b1001);

    // Sweep 2: client 1 at the right tunnel end; client 0 x moves after LATCH.
    setPos(1, 27, 19);
    runSweep(0, 0, 2);
    chk("latched_x", adL[4], 145);
    chk("c1_addr_right_wrap", adL[11], 532);
    chk("wallRight2", wallRight, 4'b1001);
    chk("wallLeft2", wallLeft, 4'b1100);
    setPos(0, 6, 5);

    // Sweep 3: reset in RD_L of client 2 (k=16).
    runSweep(0, 16, 0);
    chk("midrst_up", wallUp, 4'hF);
    chk("midrst_down", wallDown, 4'hF);
    chk("midrst_left", wallLeft, 4'hF);
    chk("midrst_right", wallRight, 4'hF);
    chk("midrst_busy", busy, 0);
    chk("midrst_romEn", romEn, 0);
    @(negedge clk);
    reset = 1'b0;
    runSweep(0, 0, 0);
    chk("post_rst_c0_first", adL[2], 118);
    chk("post_rst_valid", vL[7], 4'b0001);
    chk("post_rst_wallUp", wallUp, 4'b1101);

`ifdef WALL_GHOST_DOOR_EN
    // Client 0 below the door; (13,15)=433 is a wall in ROM.
    mem[433] = 1'b1;
    setPos(0, 13, 16);
    doorOpen = 4'b0001;
    runSweep(0, 0, 0);
    chk("door_rd_issued", adL[2], 433);
    chk("door_open_up", wallUp[0], 0);
    doorOpen = 4'b0000;
    runSweep(0, 0, 0);
    chk("door_closed_up", wallUp[0], 1);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
